// File: rtl/letter_flow_pkg.sv
// Shared constants, types and the injection script for letter_flow_gen.
package letter_flow_pkg;

    // ASCII characters used by the generator and its script
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CAP_I = 8'h49;
    localparam logic [7:0] ASCII_CAP_L = 8'h4C;
    localparam logic [7:0] ASCII_CAP_Y = 8'h59;
    localparam logic [7:0] ASCII_LOW_O = 8'h6F;
    localparam logic [7:0] ASCII_LOW_V = 8'h76;
    localparam logic [7:0] ASCII_LOW_E = 8'h65;
    localparam logic [7:0] ASCII_LOW_U = 8'h75;

    localparam logic [7:0] CAP_BASE = 8'h41;
    localparam logic [7:0] LOW_BASE = 8'h61;

    // Galois right-shift tap mask shared by both LFSRs
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Script is ten steps long; index of the final step
    localparam logic [3:0] SCRIPT_LAST = 4'd9;

    typedef enum logic {
        RAND,
        INJ
    } state_t;

    typedef enum logic [1:0] {
        LANE_NONE,
        LANE_CAP,
        LANE_LOW
    } lane_t;

    typedef struct packed {
        lane_t      lane;
        logic [7:0] ch;
    } script_step_t;

    // One Galois step of a 16-bit right-shift LFSR
    function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // An all-zero seed would lock the LFSR, so it is promoted to 1
    function automatic logic [15:0] seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

    // Script walking a checker from "wait for I" through "I Love You"
    function automatic script_step_t script_step(input logic [3:0] idx);
        script_step_t s;
        s.lane = LANE_NONE;
        s.ch   = ASCII_SPACE;
        case (idx)
            4'd0: begin s.lane = LANE_CAP; s.ch = ASCII_CAP_I; end
            4'd2: begin s.lane = LANE_CAP; s.ch = ASCII_CAP_L; end
            4'd3: begin s.lane = LANE_LOW; s.ch = ASCII_LOW_O; end
            4'd4: begin s.lane = LANE_LOW; s.ch = ASCII_LOW_V; end
            4'd5: begin s.lane = LANE_LOW; s.ch = ASCII_LOW_E; end
            4'd7: begin s.lane = LANE_CAP; s.ch = ASCII_CAP_Y; end
            4'd8: begin s.lane = LANE_LOW; s.ch = ASCII_LOW_O; end
            4'd9: begin s.lane = LANE_LOW; s.ch = ASCII_LOW_U; end
            default: begin s.lane = LANE_NONE; s.ch = ASCII_SPACE; end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/letter_flow_gen_lfsr16_letter.sv
// 16-bit Galois LFSR exposing its next value and a 0..25 letter index.
module lfsr16_letter
    import letter_flow_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [15:0] next_val,
    output logic [4:0]  letter_idx
);

    localparam logic [15:0] SEED_EFF = seed_fix(SEED);

    logic [15:0] lfsr_q;

    // Next value and letter index derived from it (folded into 0..25)
    always_comb begin
        next_val   = lfsr_advance(lfsr_q);
        letter_idx = (next_val[4:0] >= 5'd26) ? (next_val[4:0] - 5'd26) : next_val[4:0];
    end

    // LFSR register: reload has priority over stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else if (load) begin
            lfsr_q <= SEED_EFF;
        end else if (step) begin
            lfsr_q <= next_val;
        end
    end

endmodule

// File: rtl/letter_flow_gen.sv
// Two-lane ASCII letter source with an injectable "I Love You" script.
module letter_flow_gen
    import letter_flow_pkg::*;
#(
    parameter logic [15:0] SEED_CAP = 16'hACE1,
    parameter logic [15:0] SEED_LOW = 16'h1D2B,
    parameter int unsigned STEP_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       seed_load,
    input  logic       inject,
    output logic [7:0] cap_flow,
    output logic [7:0] low_flow,
    output logic       inj_busy,
    output logic       inj_done
);

    localparam logic [3:0] HOLD_LAST = 4'(STEP_CYC - 1);

    state_t       state_q, state_d;
    logic [3:0]   step_q, step_d;
    logic [3:0]   hold_q, hold_d;
    logic [7:0]   cap_d, low_d;
    logic         done_d;
    logic         lfsr_step;
    logic [4:0]   cap_idx, low_idx;
    logic [15:0]  cap_next_unused, low_next_unused;
    logic [7:0]   rand_cap, rand_low;
    logic         show_script;
    logic [3:0]   show_idx;
    script_step_t cur_step;

    assign lfsr_step = en && !seed_load;

    lfsr16_letter #(.SEED(SEED_CAP)) u_lfsr_cap (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seed_load),
        .step       (lfsr_step),
        .next_val   (cap_next_unused),
        .letter_idx (cap_idx)
    );

    lfsr16_letter #(.SEED(SEED_LOW)) u_lfsr_low (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seed_load),
        .step       (lfsr_step),
        .next_val   (low_next_unused),
        .letter_idx (low_idx)
    );

    assign inj_busy = (state_q == INJ);

    // Random letters for this cycle, taken from the LFSRs' next values
    always_comb begin
        rand_cap = CAP_BASE + {3'b000, cap_idx};
        rand_low = LOW_BASE + {3'b000, low_idx};
    end

    // Next state, step/hold counters and lane contents
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        hold_d      = hold_q;
        cap_d       = cap_flow;
        low_d       = low_flow;
        done_d      = 1'b0;
        show_script = 1'b0;
        show_idx    = step_q;
        cur_step    = script_step(4'd0);

        if (seed_load) begin
            state_d = RAND;
            step_d  = '0;
            hold_d  = '0;
        end else if (en) begin
            cap_d = rand_cap;
            low_d = rand_low;
            unique case (state_q)
                RAND: begin
                    if (inject) begin
                        state_d     = INJ;
                        step_d      = '0;
                        hold_d      = '0;
                        show_script = 1'b1;
                        show_idx    = '0;
                    end
                end
                INJ: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (step_q == SCRIPT_LAST) begin
                            state_d = RAND;
                            step_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            step_d      = step_q + 4'd1;
                            show_script = 1'b1;
                            show_idx    = step_q + 4'd1;
                        end
                    end else begin
                        hold_d      = hold_q + 4'd1;
                        show_script = 1'b1;
                        show_idx    = step_q;
                    end
                end
            endcase

            // The scripted lane overrides its random letter; the other lane stays random
            if (show_script) begin
                cur_step = script_step(show_idx);
                case (cur_step.lane)
                    LANE_CAP: cap_d = cur_step.ch;
                    LANE_LOW: low_d = cur_step.ch;
                    default:  ;
                endcase
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RAND;
            step_q   <= '0;
            hold_q   <= '0;
            cap_flow <= ASCII_SPACE;
            low_flow <= ASCII_SPACE;
            inj_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            cap_flow <= cap_d;
            low_flow <= low_d;
            inj_done <= done_d;
        end
    end

endmodule

// File: tb/tb_letter_flow_gen.sv
// Self-checking bench: two DUTs (STEP_CYC=1 and 3) against a behavioural model.
module tb_letter_flow_gen;

    localparam int SEED_CAP = 'hACE1;
    localparam int SEED_LOW = 'h1D2B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic seed_load = 1'b0;
    logic inject = 1'b0;

    logic [7:0] cap1, low1, cap3, low3;
    logic       busy1, done1, busy3, done3;

    always #5 clk = ~clk;

    letter_flow_gen #(.SEED_CAP(16'hACE1), .SEED_LOW(16'h1D2B), .STEP_CYC(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .inject(inject),
        .cap_flow(cap1), .low_flow(low1), .inj_busy(busy1), .inj_done(done1)
    );

    letter_flow_gen #(.SEED_CAP(16'hACE1), .SEED_LOW(16'h1D2B), .STEP_CYC(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .inject(inject),
        .cap_flow(cap3), .low_flow(low3), .inj_busy(busy3), .inj_done(done3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 0;
    bit rng_on   = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Script as lane (0 none, 1 cap, 2 low) and character, per step
    int         scr_lane [10] = '{1, 0, 1, 2, 2, 2, 0, 1, 2, 2};
    logic [7:0] scr_ch   [10] = '{8'h49, 8'h00, 8'h4C, 8'h6F, 8'h76, 8'h65, 8'h00, 8'h59, 8'h6F, 8'h75};
    int         m_hold   [2]  = '{1, 3};

    int         m_lc [2];
    int         m_ll [2];
    int         m_k  [2];     // enabled cycles into the script, -1 when idle
    logic [7:0] m_cap [2];
    logic [7:0] m_low [2];
    bit         m_done [2];

    function automatic int lfsr_adv(input int l);
        return (l >> 1) ^ (((l & 1) != 0) ? 'hB400 : 0);
    endfunction

    function automatic logic [7:0] letter_of(input int l, input logic [7:0] base);
        int i;
        i = l % 32;
        if (i >= 26) i -= 26;
        return base + 8'(i);
    endfunction

    task automatic overlay(input int d, input int s);
        if (scr_lane[s] == 1) m_cap[d] = scr_ch[s];
        else if (scr_lane[s] == 2) m_low[d] = scr_ch[s];
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_lc[d] = SEED_CAP; m_ll[d] = SEED_LOW;
                m_cap[d] = 8'h20; m_low[d] = 8'h20;
                m_k[d] = -1; m_done[d] = 0;
            end else if (seed_load) begin
                m_lc[d] = SEED_CAP; m_ll[d] = SEED_LOW;
                m_k[d] = -1; m_done[d] = 0;
            end else if (en) begin
                m_lc[d] = lfsr_adv(m_lc[d]);
                m_ll[d] = lfsr_adv(m_ll[d]);
                m_cap[d] = letter_of(m_lc[d], 8'h41);
                m_low[d] = letter_of(m_ll[d], 8'h61);
                m_done[d] = 0;
                if (m_k[d] < 0) begin
                    if (inject) begin
                        m_k[d] = 0;
                        overlay(d, 0);
                    end
                end else begin
                    m_k[d]++;
                    if (m_k[d] == 10 * m_hold[d]) begin
                        m_k[d] = -1;
                        m_done[d] = 1;
                    end else begin
                        overlay(d, m_k[d] / m_hold[d]);
                    end
                end
            end else begin
                m_done[d] = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_on) begin
            check_eq("cap_s1",  {8'h00, cap1}, {8'h00, m_cap[0]});
            check_eq("low_s1",  {8'h00, low1}, {8'h00, m_low[0]});
            check_eq("busy_s1", {15'd0, busy1}, {15'd0, (m_k[0] >= 0)});
            check_eq("done_s1", {15'd0, done1}, {15'd0, m_done[0]});
            check_eq("cap_s3",  {8'h00, cap3}, {8'h00, m_cap[1]});
            check_eq("low_s3",  {8'h00, low3}, {8'h00, m_low[1]});
            check_eq("busy_s3", {15'd0, busy3}, {15'd0, (m_k[1] >= 0)});
            check_eq("done_s3", {15'd0, done3}, {15'd0, m_done[1]});
        end
        if (rng_on) begin
            check_eq("cap_range_s1", {15'd0, (cap1 >= 8'h41 && cap1 <= 8'h5A)}, 16'd1);
            check_eq("low_range_s1", {15'd0, (low1 >= 8'h61 && low1 <= 8'h7A)}, 16'd1);
            check_eq("cap_range_s3", {15'd0, (cap3 >= 8'h41 && cap3 <= 8'h5A)}, 16'd1);
            check_eq("low_range_s3", {15'd0, (low3 >= 8'h61 && low3 <= 8'h7A)}, 16'd1);
        end
    end

    // Drive inputs, then advance one clock edge
    task automatic cyc(input bit e, input bit inj, input bit sl);
        en = e;
        inject = inj;
        seed_load = sl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int n_en;
        bit e;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        cmp_on = 1;
        check_eq("rst_cap", {8'h00, cap1}, 16'h0020);
        check_eq("rst_low", {8'h00, low1}, 16'h0020);
        check_eq("rst_busy", {15'd0, busy1}, 16'd0);
        check_eq("rst_done", {15'd0, done1}, 16'd0);

        // First enabled edge after reset
        rst_n = 1;
        cyc(1, 0, 0);
        check_eq("first_cap", {8'h00, cap1}, 16'h0051);
        check_eq("first_low", {8'h00, low1}, 16'h0076);
        check_eq("first_cap_s3", {8'h00, cap3}, 16'h0051);

        // Script with STEP_CYC=1, plus a stray inject while busy
        cyc(1, 1, 0);
        check_eq("s0_cap_I", {8'h00, cap1}, 16'h0049);
        check_eq("s0_busy", {15'd0, busy1}, 16'd1);
        n = 1;
        while (!done1 && n < 30) begin
            cyc(1, (n == 5), 0);
            n++;
        end
        check_eq("s1_done_edge", 16'(n), 16'd11);
        check_eq("s1_busy_after", {15'd0, busy1}, 16'd0);
        repeat (25) cyc(1, 0, 0);

        // STEP_CYC=3 with en toggling
        cyc(1, 1, 0);
        n_en = 1;
        n = 0;
        e = 0;
        while (!done3 && n < 200) begin
            cyc(e, 0, 0);
            if (e) n_en++;
            e = !e;
            n++;
        end
        check_eq("s3_done_en_edges", 16'(n_en), 16'd31);

        // seed_load mid-script
        cyc(1, 1, 0);
        repeat (4) cyc(1, 0, 0);
        check_eq("pre_sl_low_v", {8'h00, low1}, 16'h0076);
        cyc(1, 0, 1);
        check_eq("sl_busy", {15'd0, busy1}, 16'd0);
        check_eq("sl_done", {15'd0, done1}, 16'd0);
        check_eq("sl_busy_s3", {15'd0, busy3}, 16'd0);
        cyc(1, 0, 0);
        check_eq("sl_cap_Q", {8'h00, cap1}, 16'h0051);
        check_eq("sl_low_v", {8'h00, low1}, 16'h0076);
        check_eq("sl_cap_Q_s3", {8'h00, cap3}, 16'h0051);

        // Asynchronous reset at script step 6
        cyc(1, 1, 0);
        repeat (6) cyc(1, 0, 0);
        #2;
        rst_n = 0;
        #1;
        check_eq("arst_cap", {8'h00, cap1}, 16'h0020);
        check_eq("arst_low", {8'h00, low1}, 16'h0020);
        check_eq("arst_busy", {15'd0, busy1}, 16'd0);
        check_eq("arst_cap_s3", {8'h00, cap3}, 16'h0020);
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc(1, 0, 0);

        // Randomized run with range checks
        rng_on = 1;
        repeat (2000) cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 99) == 0);
        rng_on = 0;
        cyc(0, 0, 0);
        cmp_on = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
